// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions for the pipeline controller: stall vector, address type,
// controller state encoding and the priority stall resolver.
package pipe_ctrl_pkg;

    typedef logic [31:0] InstAddr_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic stall_wb;
    } Stall_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } PipeCtrlState_t;

    localparam int WDOG_W = 16;

    // The latest requesting stage freezes itself and everything upstream of it.
    function automatic Stall_t resolve_stall(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
        Stall_t s;
        s.stall_wb  = 1'b0;
        s.stall_mem = req_mem;
        s.stall_ex  = req_mem | req_ex;
        s.stall_id  = req_mem | req_ex | req_id;
        s.stall_if  = req_mem | req_ex | req_id | req_if;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and emits a one-cycle pulse
// once STALL_TIMEOUT of them have accumulated.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stalled,
    input  logic clr,
    output logic stall_timeout
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(STALL_TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else if (clr || !stalled) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else if (cnt == LAST) begin
            // Restart the count so a persistent livelock keeps pulsing periodically.
            cnt           <= '0;
            stall_timeout <= 1'b1;
        end else begin
            cnt           <= cnt + 1'b1;
            stall_timeout <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: priority stall resolution, exception/ERET entry
// (drain MEM, flush, redirect fetch) and a livelock watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      stallreq_if,
    input  logic      stallreq_id,
    input  logic      stallreq_ex,
    input  logic      stallreq_mem,
    input  logic      except_valid,
    input  InstAddr_t except_vec,
    input  logic      eret_valid,
    input  InstAddr_t epc,
    output Stall_t    stall,
    output logic      flush,
    output logic      redirect_valid,
    output InstAddr_t redirect_pc,
    output logic      stall_timeout
);

    PipeCtrlState_t state;
    InstAddr_t      target_q;
    InstAddr_t      ev_target;
    Stall_t         req_stall;
    logic           ev;
    logic           front_hold;

    assign ev        = except_valid | eret_valid;
    assign ev_target = except_valid ? except_vec : epc;
    assign req_stall = resolve_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);

    // Front hold keeps younger instructions out of the way while the faulting
    // instruction drains from MEM into WB.
    always_comb begin
        stall      = req_stall;
        front_hold = 1'b0;
        case (state)
            RUN:      front_hold = ev;
            WAIT_MEM: front_hold = 1'b1;
            FLUSH:    stall      = '0;
            default:  front_hold = 1'b0;
        endcase
        if (front_hold) begin
            stall.stall_if = 1'b1;
            stall.stall_id = 1'b1;
            stall.stall_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            target_q       <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (ev) begin
                        target_q <= ev_target;
                        if (stallreq_mem) begin
                            state <= WAIT_MEM;
                        end else begin
                            state          <= FLUSH;
                            flush          <= 1'b1;
                            redirect_valid <= 1'b1;
                            redirect_pc    <= ev_target;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (!stallreq_mem) begin
                        state          <= FLUSH;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target_q;
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_wdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .stalled      (|stall),
        .clr          (state == FLUSH),
        .stall_timeout(stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model queues the expected
// outputs per cycle; an independent monitor pops and compares on the falling edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TO = 4;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic      except_valid = 1'b0, eret_valid = 1'b0;
    InstAddr_t except_vec = '0, epc = '0;
    Stall_t    stall;
    logic      flush, redirect_valid, stall_timeout;
    InstAddr_t redirect_pc;

    pipe_ctrl #(.STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .except_valid(except_valid), .except_vec(except_vec),
        .eret_valid(eret_valid), .epc(epc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  st;   // {if, id, ex, mem, wb}
        logic        fl;
        logic        rv;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state, described in terms of pending work rather than FSM states.
    bit          m_flush_now;   // this cycle is the flush/redirect cycle
    bit          m_draining;    // event taken, waiting for MEM to finish its bus access
    logic [31:0] m_target;
    logic [31:0] m_pc;
    int          m_streak;      // stalled cycles since the watchdog last cleared
    bit          m_to;

    function automatic logic [4:0] priority_stall(input logic [3:0] req);
        int lvl;
        logic [4:0] s;
        // req = {if, id, ex, mem}; stage number 1..4 of the latest requester
        lvl = req[0] ? 4 : req[1] ? 3 : req[2] ? 2 : req[3] ? 1 : 0;
        s = '0;
        for (int k = 1; k <= 4; k++) s[5-k] = (k <= lvl);
        return s;
    endfunction

    task automatic model_step();
        exp_t e;
        logic [3:0] req;
        bit ev;
        req = {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem};
        ev  = except_valid || eret_valid;
        if (!rst_n) begin
            m_flush_now = 0; m_draining = 0; m_target = '0; m_pc = '0;
            m_streak = 0; m_to = 0;
            e = '{st: priority_stall(req), fl: 1'b0, rv: 1'b0, pc: 32'h0, to: 1'b0};
            expq.push_back(e);
            return;
        end
        e.fl = m_flush_now;
        e.rv = m_flush_now;
        e.pc = m_pc;
        e.to = m_to;
        if (m_flush_now) e.st = '0;
        else begin
            e.st = priority_stall(req);
            if (m_draining || ev) e.st[4:2] = 3'b111;
        end
        expq.push_back(e);
        if (|e.st) begin
            m_streak++;
            m_to = (m_streak == TO);
            if (m_to) m_streak = 0;
        end else begin
            m_streak = 0;
            m_to = 0;
        end
        if (m_flush_now) m_flush_now = 0;
        else if (m_draining || ev) begin
            if (!m_draining) m_target = except_valid ? except_vec : epc;
            if (stallreq_mem) m_draining = 1;
            else begin
                m_draining = 0;
                m_flush_now = 1;
                m_pc = m_target;
            end
        end
    endtask

    task automatic drive(input bit rn, input logic [3:0] req, input bit exc, input bit er,
                         input logic [31:0] vec, input logic [31:0] ep);
        @(posedge clk);
        #1;
        rst_n = rn;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = req;
        except_valid = exc;
        eret_valid   = er;
        except_vec   = vec;
        epc          = ep;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 4'b0000, 0, 0, 32'h0, 32'h0);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = '{st: stall, fl: flush, rv: redirect_valid, pc: redirect_pc, to: stall_timeout};
                tests++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d: got stall=%b flush=%b rv=%b pc=%h to=%b, want stall=%b flush=%b rv=%b pc=%h to=%b",
                             cyc, a.st, a.fl, a.rv, a.pc, a.to, e.st, e.fl, e.rv, e.pc, e.to);
                end
            end
        end
    end

    initial begin
        // Reset held: registered outputs 0, stall follows requests.
        drive(0, 4'b0000, 0, 0, 0, 0);
        drive(0, 4'b0010, 0, 0, 0, 0);
        drive(0, 4'b0001, 0, 0, 0, 0);
        // Stall resolution
        drive(1, 4'b0010, 0, 0, 0, 0);
        drive(1, 4'b0001, 0, 0, 0, 0);
        drive(1, 4'b1000, 0, 0, 0, 0);
        drive(1, 4'b0100, 0, 0, 0, 0);
        drive(1, 4'b1110, 0, 0, 0, 0);
        idle(1);
        // Exception with no MEM stall
        drive(1, 4'b0000, 1, 0, 32'hBFC00380, 0);
        idle(3);
        // Exception during MEM stall; vector changes after capture
        drive(1, 4'b0001, 1, 0, 32'hBFC00380, 0);
        drive(1, 4'b0001, 0, 0, 32'h11111111, 0);
        drive(1, 4'b0001, 1, 0, 32'h22222222, 0);
        drive(1, 4'b0001, 0, 1, 32'h33333333, 32'h44444444);
        drive(1, 4'b0000, 0, 0, 32'h55555555, 0);
        idle(3);
        // Simultaneous exception and ERET: exception wins
        drive(1, 4'b0000, 1, 1, 32'h80000180, 32'h80001000);
        idle(2);
        // ERET alone
        drive(1, 4'b0100, 0, 1, 32'h80000180, 32'h80001000);
        idle(2);
        // Watchdog: long stall pulses, short stall does not
        for (int i = 0; i < 10; i++) drive(1, 4'b0100, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) drive(1, 4'b0100, 0, 0, 0, 0);
        idle(2);
        // Reset while draining MEM: no flush, then a fresh exception works
        drive(1, 4'b0001, 1, 0, 32'hDEAD0000, 0);
        drive(1, 4'b0001, 0, 0, 0, 0);
        drive(0, 4'b0001, 0, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0);
        idle(3);
        drive(1, 4'b0000, 1, 0, 32'hBFC00200, 0);
        idle(2);
        // Stall request during the flush cycle is masked, honoured next cycle
        drive(1, 4'b0000, 1, 0, 32'h0000ABCD, 0);
        drive(1, 4'b1111, 1, 1, 32'h12345678, 32'h9ABCDEF0);
        drive(1, 4'b1111, 0, 0, 0, 0);
        idle(2);
        // Randomized traffic including occasional resets
        for (int i = 0; i < 1500; i++) begin
            bit rn, exc, er;
            logic [3:0] req;
            rn  = ($urandom_range(0, 99) != 0);
            req = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 3)};
            exc = rn && ($urandom_range(0, 11) == 0);
            er  = rn && ($urandom_range(0, 11) == 0);
            drive(rn, req, exc, er, $urandom, $urandom);
        end
        idle(2);
        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. Resolves per-stage stall requests into the `Stall_t` vector consumed by every pipeline register, including the MEM/WB register. Sequences exception and ERET entry as: drain MEM, flush, redirect fetch. Also runs a stall watchdog that flags livelocked bus stalls.

## Interface
- `STALL_TIMEOUT`, default 1024: consecutive stalled cycles before `stall_timeout` pulses; legal range 2..65535.
- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous active-low reset
- `stallreq_if`  in  1  fetch stage requests stall
- `stallreq_id`  in  1  decode stage requests stall (load-use, branch hazard)
- `stallreq_ex`  in  1  execute stage requests stall (multi-cycle mul/div)
- `stallreq_mem`  in  1  memory stage requests stall (outstanding bus transaction)
- `except_valid`  in  1  MEM-stage instruction raised an exception
- `except_vec`  in  32 (`InstAddr_t`)  exception handler address
- `eret_valid`  in  1  MEM-stage instruction is ERET
- `epc`  in  32 (`InstAddr_t`)  return address for ERET
- `stall`  out  `Stall_t`  fields `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, `stall_wb`
- `flush`  out  1  clears all pipeline registers
- `redirect_valid`  out  1  fetch must load `redirect_pc`
- `redirect_pc`  out  32 (`InstAddr_t`)  fetch redirect target
- `stall_timeout`  out  1  one-cycle watchdog pulse

Clock and reset are decided: one clock, reset asynchronous and active-low.

## Operation
- Stall resolution is combinational in RUN. The latest requesting stage stalls itself and every earlier stage; later stages are not stalled.
  - `stallreq_mem` gives if/id/ex/mem = 1, wb = 0.
  - `stallreq_ex` gives if/id/ex = 1.
  - `stallreq_id` gives if/id = 1.
  - `stallreq_if` gives if = 1.
  - `stall_wb` is always 0.
- States are RUN, WAIT_MEM and FLUSH.
- An event is `except_valid || eret_valid`. If both are high, the exception wins. The target is `except_vec` for an exception and `epc` for ERET.
- RUN with an event and `stallreq_mem` = 0:
  - Latch the target.
  - Force if/id/ex stall for this cycle with mem = 0, so the faulting instruction, with its CP0 write, retires into WB.
  - Go to FLUSH.
- RUN with an event and `stallreq_mem` = 1:
  - Latch the target.
  - Go to WAIT_MEM.
- WAIT_MEM:
  - Stall output follows normal resolution, with `stall_if`/`stall_id`/`stall_ex` forced to 1.
  - Event inputs are ignored.
  - When `stallreq_mem` = 0, go to FLUSH, using the same forced front-stall as the RUN transition.
- FLUSH lasts exactly one cycle:
  - `flush` = 1, `redirect_valid` = 1, `redirect_pc` = latched target, all stall fields = 0.
  - Event inputs are ignored.
  - Return to RUN.
- Watchdog:
  - A 16-bit counter increments on every cycle where any `stall` field is 1, and clears on any cycle with none.
  - When it reaches `STALL_TIMEOUT - 1` while stalled, `stall_timeout` pulses the next cycle and the counter returns to 0.
  - FLUSH cycles clear the counter.

## Timing
- Reset values: state RUN, latched target 0, counter 0, `flush` 0, `redirect_valid` 0, `redirect_pc` 0, `stall_timeout` 0. `stall` equals the combinational resolution of the request inputs.
- Stall latency is 0 cycles: request to `stall` within the same cycle.
- Event latency:
  - Event in cycle N with no MEM stall: `flush`/`redirect_valid` in N+1.
  - With a MEM stall: `flush` in the cycle after `stallreq_mem` falls.
- `flush`, `redirect_valid`, `redirect_pc` and `stall_timeout` are registered outputs.
- `rst_n` asserted mid-sequence, in WAIT_MEM or FLUSH, returns immediately to RUN with no flush emitted.
- A stall request in the FLUSH cycle is masked. It is honoured from the following cycle.

## Structure
- `Stall_t`, `InstAddr_t` and the state enum `PipeCtrlState_t` belong in the shared CPU definitions header.
- Sub-module `stall_watchdog` holds the counter and the pulse, parameterised by `STALL_TIMEOUT`.

## Test plan
- Reset and stall resolution:
  - Hold `rst_n` = 0: all outputs read 0 and state is RUN.
  - Release, then drive `stallreq_ex` = 1 alone → `stall` if/id/ex = 1, mem/wb = 0 in the same cycle.
  - Drive `stallreq_mem` = 1 → if/id/ex/mem = 1, wb = 0.
- Exception, no MEM stall: `except_valid` = 1, `except_vec` = 0xBFC00380 in cycle N.
  - Cycle N: if/id/ex = 1, mem = 0.
  - Cycle N+1: `flush` = 1, `redirect_valid` = 1, `redirect_pc` = 0xBFC00380.
  - Cycle N+2: `flush` = 0.
- Exception during MEM stall: `except_valid` pulse while `stallreq_mem` is held 3 more cycles.
  - No `flush` while `stallreq_mem` is high.
  - `flush` 1 cycle after `stallreq_mem` drops.
  - `redirect_pc` holds the vector captured at the pulse, even though `except_vec` changed afterwards.
- Simultaneous events: `except_valid` and `eret_valid` in the same cycle with `epc` = 0x80001000 and `except_vec` = 0x80000180 → `redirect_pc` = 0x80000180.
- Watchdog: `STALL_TIMEOUT` = 4, hold `stallreq_id` = 1 for 10 cycles.
  - `stall_timeout` pulses on cycles 5 and 9 after the stall starts.
  - Dropping the stall before cycle 4 produces no pulse.
- Reset mid-sequence: assert `rst_n` = 0 while in WAIT_MEM → no `flush` ever emitted. After release, a new exception is handled normally.
